// File: rtl/io_port_arbiter_pkg.sv
// rtl/io_port_arbiter_pkg.sv - shared widths, id sizing and read-tag type for the IO port arbiter
package io_port_arbiter_pkg;

   localparam int NUM_REQ       = 4;
   localparam int IO_DATA_WIDTH = 256;
   localparam int IO_ADDR_WIDTH = 16;
   localparam int RD_LATENCY    = 1;

   function automatic int req_id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int REQ_ID_WIDTH = req_id_width(NUM_REQ);

   typedef struct packed {
      logic                    valid;
      logic [REQ_ID_WIDTH-1:0] id;
   } rd_tag_t;

endpackage

// File: rtl/io_port_arbiter_if.sv
// rtl/io_port_arbiter_if.sv - requester and IO-buffer signal bundle for the IO port arbiter
interface io_port_arbiter_if
   import io_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ       = io_port_arbiter_pkg::NUM_REQ,
   parameter int IO_DATA_WIDTH = io_port_arbiter_pkg::IO_DATA_WIDTH,
   parameter int IO_ADDR_WIDTH = io_port_arbiter_pkg::IO_ADDR_WIDTH
) ();

   logic [NUM_REQ-1:0]               req_rd_en;
   logic [NUM_REQ*IO_ADDR_WIDTH-1:0] req_rd_addr;
   logic [NUM_REQ-1:0]               rd_gnt;
   logic [NUM_REQ-1:0]               rd_valid;
   logic [IO_DATA_WIDTH-1:0]         rd_data;
   logic [NUM_REQ-1:0]               req_wr_en;
   logic [NUM_REQ*IO_ADDR_WIDTH-1:0] req_wr_addr;
   logic [NUM_REQ*IO_DATA_WIDTH-1:0] req_wr_data;
   logic [NUM_REQ-1:0]               wr_gnt;
   logic                             mem_rd_en;
   logic [IO_ADDR_WIDTH-1:0]         mem_rd_addr;
   logic [IO_DATA_WIDTH-1:0]         mem_rd_data;
   logic                             mem_wr_en;
   logic [IO_ADDR_WIDTH-1:0]         mem_wr_addr;
   logic [IO_DATA_WIDTH-1:0]         mem_wr_data;

   modport slave (
      input  req_rd_en, req_rd_addr, req_wr_en, req_wr_addr, req_wr_data, mem_rd_data,
      output rd_gnt, rd_valid, rd_data, wr_gnt,
      output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
   );

   modport master (
      output req_rd_en, req_rd_addr, req_wr_en, req_wr_addr, req_wr_data, mem_rd_data,
      input  rd_gnt, rd_valid, rd_data, wr_gnt,
      input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
   );

endinterface

// File: rtl/io_port_arbiter_rr_arbiter.sv
// rtl/io_port_arbiter_rr_arbiter.sv - combinational round-robin pick: first request at or above ptr, wrapping
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] winner,
   output logic           any
);

   always_comb begin
      gnt    = '0;
      winner = '0;
      any    = 1'b0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (int'(ptr) + k) % N;
         if (!any && req[idx]) begin
            any      = 1'b1;
            winner   = IDW'(idx);
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_port_arbiter.sv
// rtl/io_port_arbiter.sv - shares one IO buffer port among NUM_REQ requesters with per-channel round-robin
module io_port_arbiter
   import io_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ       = io_port_arbiter_pkg::NUM_REQ,
   parameter int IO_DATA_WIDTH = io_port_arbiter_pkg::IO_DATA_WIDTH,
   parameter int IO_ADDR_WIDTH = io_port_arbiter_pkg::IO_ADDR_WIDTH,
   parameter int RD_LATENCY    = io_port_arbiter_pkg::RD_LATENCY
) (
   input logic              clk,
   input logic              rst_n,
   io_port_arbiter_if.slave bus
);

   localparam int IDW = req_id_width(NUM_REQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

   typedef struct packed {
      logic           valid;
      logic [IDW-1:0] id;
   } id_entry_t;

   logic [IDW-1:0]     rd_ptr, wr_ptr, rd_win, wr_win, rd_cmd_id;
   logic               rd_any, wr_any;
   logic [NUM_REQ-1:0] rd_gnt_c, wr_gnt_c;
   id_entry_t          id_pipe [RD_LATENCY];
   id_entry_t          tail;

   logic                     mem_rd_en_q, mem_wr_en_q;
   logic [IO_ADDR_WIDTH-1:0] mem_rd_addr_q, mem_wr_addr_q;
   logic [IO_DATA_WIDTH-1:0] mem_wr_data_q, rd_data_q;
   logic [NUM_REQ-1:0]       rd_valid_q;

   rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rd_arb (
      .req(bus.req_rd_en), .ptr(rd_ptr), .gnt(rd_gnt_c), .winner(rd_win), .any(rd_any)
   );

   rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_wr_arb (
      .req(bus.req_wr_en), .ptr(wr_ptr), .gnt(wr_gnt_c), .winner(wr_win), .any(wr_any)
   );

   assign tail = id_pipe[RD_LATENCY-1];

   // The mem_rd_en/rd_cmd_id register is the head of the tag pipeline; id_pipe adds RD_LATENCY more stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         mem_rd_en_q   <= 1'b0;
         mem_rd_addr_q <= '0;
         rd_cmd_id     <= '0;
         mem_wr_en_q   <= 1'b0;
         mem_wr_addr_q <= '0;
         mem_wr_data_q <= '0;
         rd_valid_q    <= '0;
         rd_data_q     <= '0;
         for (int i = 0; i < RD_LATENCY; i++) id_pipe[i] <= '0;
      end else begin
         mem_rd_en_q <= rd_any;
         mem_wr_en_q <= wr_any;
         if (rd_any) begin
            rd_ptr        <= (rd_win == LAST_ID) ? '0 : rd_win + 1'b1;
            mem_rd_addr_q <= bus.req_rd_addr[int'(rd_win)*IO_ADDR_WIDTH +: IO_ADDR_WIDTH];
            rd_cmd_id     <= rd_win;
         end
         if (wr_any) begin
            wr_ptr        <= (wr_win == LAST_ID) ? '0 : wr_win + 1'b1;
            mem_wr_addr_q <= bus.req_wr_addr[int'(wr_win)*IO_ADDR_WIDTH +: IO_ADDR_WIDTH];
            mem_wr_data_q <= bus.req_wr_data[int'(wr_win)*IO_DATA_WIDTH +: IO_DATA_WIDTH];
         end
         id_pipe[0] <= '{valid: mem_rd_en_q, id: rd_cmd_id};
         for (int i = 1; i < RD_LATENCY; i++) id_pipe[i] <= id_pipe[i-1];
         if (tail.valid) begin
            rd_data_q  <= bus.mem_rd_data;
            rd_valid_q <= NUM_REQ'(1) << tail.id;
         end else begin
            rd_valid_q <= '0;
         end
      end
   end

   assign bus.rd_gnt      = rd_gnt_c;
   assign bus.wr_gnt      = wr_gnt_c;
   assign bus.mem_rd_en   = mem_rd_en_q;
   assign bus.mem_rd_addr = mem_rd_addr_q;
   assign bus.mem_wr_en   = mem_wr_en_q;
   assign bus.mem_wr_addr = mem_wr_addr_q;
   assign bus.mem_wr_data = mem_wr_data_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_data_q;

endmodule

// File: tb/tb_io_port_arbiter.sv
// tb/tb_io_port_arbiter.sv - directed bench for io_port_arbiter with read latencies 1 and 3
module tb_io_port_arbiter;

   localparam int NR = 4;
   localparam int AW = 16;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NR-1:0]    req_rd_en, req_wr_en;
   logic [NR*AW-1:0] req_rd_addr, req_wr_addr;
   logic [NR*DW-1:0] req_wr_data;

   io_port_arbiter_if #(.NUM_REQ(NR), .IO_DATA_WIDTH(DW), .IO_ADDR_WIDTH(AW)) bus1 ();
   io_port_arbiter_if #(.NUM_REQ(NR), .IO_DATA_WIDTH(DW), .IO_ADDR_WIDTH(AW)) bus3 ();

   assign bus1.req_rd_en   = req_rd_en;
   assign bus1.req_rd_addr = req_rd_addr;
   assign bus1.req_wr_en   = req_wr_en;
   assign bus1.req_wr_addr = req_wr_addr;
   assign bus1.req_wr_data = req_wr_data;
   assign bus3.req_rd_en   = req_rd_en;
   assign bus3.req_rd_addr = req_rd_addr;
   assign bus3.req_wr_en   = req_wr_en;
   assign bus3.req_wr_addr = req_wr_addr;
   assign bus3.req_wr_data = req_wr_data;

   function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
      return DW'(a) + 32'h9B;
   endfunction

   // IO buffer models: data for the sampled address appears RD_LATENCY cycles later
   logic [DW-1:0] m1;
   logic [DW-1:0] m3 [3];
   always @(posedge clk) begin
      m1    <= mem_fn(bus1.mem_rd_addr);
      m3[0] <= mem_fn(bus3.mem_rd_addr);
      m3[1] <= m3[0];
      m3[2] <= m3[1];
   end
   assign bus1.mem_rd_data = m1;
   assign bus3.mem_rd_data = m3[2];

   io_port_arbiter #(.NUM_REQ(NR), .IO_DATA_WIDTH(DW), .IO_ADDR_WIDTH(AW), .RD_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );
   io_port_arbiter #(.NUM_REQ(NR), .IO_DATA_WIDTH(DW), .IO_ADDR_WIDTH(AW), .RD_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [NR-1:0] rd;
      logic [NR-1:0] wr;
      logic [NR-1:0] erg;
      logic [NR-1:0] ewg;
      logic          emr;
      logic          emw;
   } vec_t;

   vec_t tbl [11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0};
      tbl[1]  = '{4'b1111, 4'b0110, 4'b0010, 4'b0010, 1'b1, 1'b0};
      tbl[2]  = '{4'b1111, 4'b0110, 4'b0100, 4'b0100, 1'b1, 1'b1};
      tbl[3]  = '{4'b1111, 4'b0110, 4'b1000, 4'b0010, 1'b1, 1'b1};
      tbl[4]  = '{4'b1111, 4'b1001, 4'b0001, 4'b1000, 1'b1, 1'b1};
      tbl[5]  = '{4'b1111, 4'b1001, 4'b0010, 4'b0001, 1'b1, 1'b1};
      tbl[6]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b1};
      tbl[7]  = '{4'b1111, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0};
      tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1};
      tbl[9]  = '{4'b1000, 4'b0001, 4'b1000, 4'b0001, 1'b0, 1'b0};
      tbl[10] = '{4'b0110, 4'b0001, 4'b0010, 4'b0001, 1'b1, 1'b1};

      rst_n     = 1'b0;
      req_rd_en = '0;
      req_wr_en = '0;
      for (int i = 0; i < NR; i++) begin
         req_rd_addr[i*AW +: AW] = AW'(16'h0100 + i);
         req_wr_addr[i*AW +: AW] = AW'(16'h0200 + i);
         req_wr_data[i*DW +: DW] = DW'(32'hD0 + i);
      end

      step();
      step();
      @(negedge clk);
      chk("reset mem_rd_en", 64'(bus1.mem_rd_en), 64'd0);
      chk("reset mem_wr_en", 64'(bus1.mem_wr_en), 64'd0);
      chk("reset rd_valid", 64'(bus1.rd_valid), 64'd0);
      chk("reset mem_rd_addr", 64'(bus1.mem_rd_addr), 64'd0);
      chk("reset mem_wr_data", 64'(bus1.mem_wr_data), 64'd0);
      chk("reset rd_gnt", 64'(bus1.rd_gnt), 64'd0);
      chk("reset rd_valid l3", 64'(bus3.rd_valid), 64'd0);
      step();
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         req_rd_en = tbl[i].rd;
         req_wr_en = tbl[i].wr;
         @(negedge clk);
         chk($sformatf("tbl%0d rd_gnt", i), 64'(bus1.rd_gnt), 64'(tbl[i].erg));
         chk($sformatf("tbl%0d wr_gnt", i), 64'(bus1.wr_gnt), 64'(tbl[i].ewg));
         chk($sformatf("tbl%0d mem_rd_en", i), 64'(bus1.mem_rd_en), 64'(tbl[i].emr));
         chk($sformatf("tbl%0d mem_wr_en", i), 64'(bus1.mem_wr_en), 64'(tbl[i].emw));
         step();
      end
      req_rd_en = '0;
      req_wr_en = '0;
      repeat (6) step();

      // single read, latency 1, read ptr is 2 here
      req_rd_addr[2*AW +: AW] = 16'h0010;
      req_rd_en = 4'b0100;
      @(negedge clk);
      chk("single rd_gnt", 64'(bus1.rd_gnt), 64'h4);
      step();
      req_rd_en = '0;
      @(negedge clk);
      chk("single mem_rd_en", 64'(bus1.mem_rd_en), 64'd1);
      chk("single mem_rd_addr", 64'(bus1.mem_rd_addr), 64'h10);
      step();
      @(negedge clk);
      chk("single early rd_valid", 64'(bus1.rd_valid), 64'd0);
      step();
      @(negedge clk);
      chk("single rd_valid", 64'(bus1.rd_valid), 64'h4);
      chk("single rd_data", 64'(bus1.rd_data), 64'hAB);
      step();

      // hold: ptr=3, requester 0 waits one cycle
      req_rd_addr[3*AW +: AW] = 16'h0033;
      req_rd_addr[0*AW +: AW] = 16'h0030;
      req_rd_en = 4'b1001;
      @(negedge clk);
      chk("hold gnt3", 64'(bus1.rd_gnt), 64'h8);
      step();
      req_rd_en = 4'b0001;
      @(negedge clk);
      chk("hold gnt0", 64'(bus1.rd_gnt), 64'h1);
      chk("hold mem_rd_addr3", 64'(bus1.mem_rd_addr), 64'h33);
      step();
      req_rd_en = '0;
      @(negedge clk);
      chk("idle gnt", 64'(bus1.rd_gnt), 64'd0);
      chk("hold mem_rd_addr0", 64'(bus1.mem_rd_addr), 64'h30);
      step();
      @(negedge clk);
      chk("idle mem_rd_en", 64'(bus1.mem_rd_en), 64'd0);
      repeat (6) step();

      // simultaneous read and write channels
      req_rd_addr[1*AW +: AW] = 16'h0020;
      req_wr_addr[2*AW +: AW] = 16'h0030;
      req_wr_data[2*DW +: DW] = 32'h55;
      req_rd_en = 4'b0010;
      req_wr_en = 4'b0100;
      @(negedge clk);
      chk("sim rd_gnt", 64'(bus1.rd_gnt), 64'h2);
      chk("sim wr_gnt", 64'(bus1.wr_gnt), 64'h4);
      step();
      req_rd_en = '0;
      req_wr_en = '0;
      @(negedge clk);
      chk("sim mem_rd_en", 64'(bus1.mem_rd_en), 64'd1);
      chk("sim mem_rd_addr", 64'(bus1.mem_rd_addr), 64'h20);
      chk("sim mem_wr_en", 64'(bus1.mem_wr_en), 64'd1);
      chk("sim mem_wr_addr", 64'(bus1.mem_wr_addr), 64'h30);
      chk("sim mem_wr_data", 64'(bus1.mem_wr_data), 64'h55);
      repeat (6) step();

      // pipelined returns on the latency-3 instance, read ptr is 2 here
      req_rd_addr[1*AW +: AW] = 16'h0041;
      req_rd_addr[3*AW +: AW] = 16'h0043;
      req_rd_addr[0*AW +: AW] = 16'h0040;
      req_rd_en = 4'b0010;
      @(negedge clk);
      chk("pipe gnt1", 64'(bus3.rd_gnt), 64'h2);
      step();
      req_rd_en = 4'b1000;
      @(negedge clk);
      chk("pipe gnt3", 64'(bus3.rd_gnt), 64'h8);
      step();
      req_rd_en = 4'b0001;
      @(negedge clk);
      chk("pipe gnt0", 64'(bus3.rd_gnt), 64'h1);
      step();
      req_rd_en = '0;
      @(negedge clk);
      chk("pipe a+3 rd_valid", 64'(bus3.rd_valid), 64'd0);
      step();
      @(negedge clk);
      chk("pipe a+4 rd_valid", 64'(bus3.rd_valid), 64'd0);
      step();
      @(negedge clk);
      chk("pipe ret1 valid", 64'(bus3.rd_valid), 64'h2);
      chk("pipe ret1 data", 64'(bus3.rd_data), 64'hDC);
      step();
      @(negedge clk);
      chk("pipe ret3 valid", 64'(bus3.rd_valid), 64'h8);
      chk("pipe ret3 data", 64'(bus3.rd_data), 64'hDE);
      step();
      @(negedge clk);
      chk("pipe ret0 valid", 64'(bus3.rd_valid), 64'h1);
      chk("pipe ret0 data", 64'(bus3.rd_data), 64'hDB);
      step();
      @(negedge clk);
      chk("pipe after valid", 64'(bus3.rd_valid), 64'd0);
      step();

      // reset with reads in flight, read ptr is 1 here
      req_rd_en = 4'b0100;
      @(negedge clk);
      chk("rst pre gnt2", 64'(bus1.rd_gnt), 64'h4);
      step();
      req_rd_en = 4'b1000;
      @(negedge clk);
      chk("rst pre gnt3", 64'(bus1.rd_gnt), 64'h8);
      step();
      req_rd_en = '0;
      rst_n = 1'b0;
      #1;
      chk("rst async mem_rd_en l1", 64'(bus1.mem_rd_en), 64'd0);
      chk("rst async mem_rd_en l3", 64'(bus3.mem_rd_en), 64'd0);
      chk("rst async mem_rd_addr", 64'(bus1.mem_rd_addr), 64'd0);
      chk("rst async rd_valid", 64'(bus1.rd_valid), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("post rst rd_valid l1 c%0d", i), 64'(bus1.rd_valid), 64'd0);
         chk($sformatf("post rst rd_valid l3 c%0d", i), 64'(bus3.rd_valid), 64'd0);
         step();
      end
      req_rd_en = 4'b1111;
      @(negedge clk);
      chk("post rst gnt0 l1", 64'(bus1.rd_gnt), 64'h1);
      chk("post rst gnt0 l3", 64'(bus3.rd_gnt), 64'h1);
      step();
      req_rd_en = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
